input_conditioner: RTL and testbench

//  Parametrised multi-channel input front end. Successor to the single-bit

---
 rtl/input_cond_pkg.sv | 18 +
 rtl/input_cond_ch.sv | 120 ++++++++++++
 rtl/input_conditioner.sv | 111 +++++++++++
 tb/tb_input_conditioner.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/input_cond_pkg.sv
// rtl/input_cond_pkg.sv - shared types and default parameters for the input conditioner
// Purpose: output-mode encoding and default channel/width constants used by
//          input_conditioner and input_cond_ch.
package input_cond_pkg;

    typedef enum logic [1:0] {
        MODE_LEVEL  = 2'b00,
        MODE_RISE   = 2'b01,
        MODE_FALL   = 2'b10,
        MODE_TOGGLE = 2'b11
    } mode_t;

    localparam int DEF_N_CH        = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DB_WIDTH    = 4;
    localparam int DEF_CNT_WIDTH   = 8;

endpackage

// File: rtl/input_cond_ch.sv
// rtl/input_cond_ch.sv - one conditioned input channel
// Purpose: synchroniser, polarity, debounce, edge detect, toggle latch and
//          saturating rise counter for a single input bit.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   ena_i          1 = debounce/edge/toggle logic runs
//   din_i          raw asynchronous input
//   invert_i       invert the synchronised input
//   prime_load_i   one-cycle pulse: load debounced level from current input
//   primed_i       prime finished, debounce may run
//   mode_i         output select
//   db_limit_i     debounce length
//   cnt_clr_i      synchronous counter clear
//   dout_o         selected output
//   rise_o         registered rise pulse
//   count_o        saturating rise count
module input_cond_ch
    import input_cond_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_WIDTH    = DEF_DB_WIDTH,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena_i,
    input  logic                 din_i,
    input  logic                 invert_i,
    input  logic                 prime_load_i,
    input  logic                 primed_i,
    input  mode_t                mode_i,
    input  logic [DB_WIDTH-1:0]  db_limit_i,
    input  logic                 cnt_clr_i,
    output logic                 dout_o,
    output logic                 rise_o,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   db_q, db_d;
    logic [DB_WIDTH-1:0]    db_cnt_q, db_cnt_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   tgl_q, tgl_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   s;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], din_i};
    assign s      = sync_q[SYNC_STAGES-1] ^ invert_i;

    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        cnt_d    = cnt_q;

        if (prime_load_i) begin
            // Initial level is adopted silently: no edge, toggle or count.
            db_d     = s;
            db_cnt_d = '0;
        end else if (primed_i && ena_i) begin
            if (s == db_q) begin
                db_cnt_d = '0;
            end else if (db_cnt_q >= db_limit_i) begin
                // >= rather than == so a limit lowered mid-count cannot
                // leave the counter stranded above it.
                db_d     = s;
                db_cnt_d = '0;
                rise_d   = s;
                fall_d   = ~s;
            end else begin
                db_cnt_d = db_cnt_q + DB_WIDTH'(1);
            end
        end

        tgl_d = tgl_q ^ rise_d;

        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (rise_d && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            db_q     <= 1'b0;
            db_cnt_q <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            tgl_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            tgl_q    <= tgl_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        dout_o = db_q;
        unique case (mode_i)
            MODE_LEVEL:  dout_o = db_q;
            MODE_RISE:   dout_o = rise_q;
            MODE_FALL:   dout_o = fall_q;
            MODE_TOGGLE: dout_o = tgl_q;
            default:     dout_o = db_q;
        endcase
    end

    assign rise_o  = rise_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - multi-channel input conditioner top
// Purpose: N_CH conditioned channels with a shared prime counter, an OR of
//          rise pulses and a per-channel event-count readout mux.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   ena           1 = run, 0 = freeze conditioning state
//   din           raw asynchronous inputs
//   invert_mask   per-channel polarity inversion
//   mode          output select for all channels
//   db_limit      debounce length in cycles
//   cnt_clr       synchronous clear of all counters
//   ch_sel        channel shown on evt_count
//   dout          conditioned outputs
//   any_evt       OR of all rise pulses
//   evt_count     event count of channel ch_sel (0 if out of range)
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_WIDTH    = DEF_DB_WIDTH,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic [N_CH-1:0]         din,
    input  logic [N_CH-1:0]         invert_mask,
    input  logic [1:0]              mode,
    input  logic [DB_WIDTH-1:0]     db_limit,
    input  logic                    cnt_clr,
    input  logic [$clog2(N_CH)-1:0] ch_sel,
    output logic [N_CH-1:0]         dout,
    output logic                    any_evt,
    output logic [CNT_WIDTH-1:0]    evt_count
);

    localparam int PRIME_W = $clog2(SYNC_STAGES + 1);
    localparam int SEL_W   = $clog2(N_CH);

    logic [PRIME_W-1:0] prime_cnt_q, prime_cnt_d;
    logic               primed_q, primed_d;
    logic               prime_load;

    logic [N_CH-1:0]      rise_vec;
    logic [CNT_WIDTH-1:0] cnt_arr [N_CH];
    mode_t                mode_sel;

    assign mode_sel = mode_t'(mode);

    // Once SYNC_STAGES cycles have passed the synchronisers hold real input
    // data, so that cycle's value seeds every debounced level.
    assign prime_load = !primed_q && (prime_cnt_q == PRIME_W'(SYNC_STAGES));

    always_comb begin
        prime_cnt_d = prime_cnt_q;
        primed_d    = primed_q;
        if (!primed_q) begin
            if (prime_load) begin
                primed_d = 1'b1;
            end else begin
                prime_cnt_d = prime_cnt_q + PRIME_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime_cnt_q <= '0;
            primed_q    <= 1'b0;
        end else begin
            prime_cnt_q <= prime_cnt_d;
            primed_q    <= primed_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        input_cond_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_WIDTH    (DB_WIDTH),
            .CNT_WIDTH   (CNT_WIDTH)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .ena_i        (ena),
            .din_i        (din[g]),
            .invert_i     (invert_mask[g]),
            .prime_load_i (prime_load),
            .primed_i     (primed_q),
            .mode_i       (mode_sel),
            .db_limit_i   (db_limit),
            .cnt_clr_i    (cnt_clr),
            .dout_o       (dout[g]),
            .rise_o       (rise_vec[g]),
            .count_o      (cnt_arr[g])
        );
    end

    assign any_evt = |rise_vec;

    // Unmatched selects fall through to zero.
    always_comb begin
        evt_count = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sel == SEL_W'(i)) begin
                evt_count = cnt_arr[i];
            end
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed self-checking bench for input_conditioner
module tb_input_conditioner;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] din;
    logic [7:0] invert_mask;
    logic [1:0] mode;
    logic [3:0] db_limit;
    logic       cnt_clr;
    logic [2:0] ch_sel;
    logic [7:0] dout;
    logic       any_evt;
    logic [7:0] evt_count;

    int n_checks;
    int n_errors;

    int watch_ch;
    int hi_cnt;
    int dbl_cnt;
    int evt_seen;
    logic prev_bit;

    input_conditioner dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .din         (din),
        .invert_mask (invert_mask),
        .mode        (mode),
        .db_limit    (db_limit),
        .cnt_clr     (cnt_clr),
        .ch_sel      (ch_sel),
        .dout        (dout),
        .any_evt     (any_evt),
        .evt_count   (evt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance n cycles, recording high cycles, back-to-back highs of
    // dout[watch_ch] and any any_evt activity.
    task automatic step_watch(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (dout[watch_ch]) begin
                hi_cnt++;
                if (prev_bit) dbl_cnt++;
            end
            if (any_evt) evt_seen++;
            prev_bit = dout[watch_ch];
        end
    endtask

    task automatic clear_watch(input int ch);
        watch_ch = ch;
        hi_cnt   = 0;
        dbl_cnt  = 0;
        evt_seen = 0;
        prev_bit = 1'b0;
    endtask

    // Cycles until dout[ch] first reads 1, 0 if not within limit.
    task automatic wait_rise(input int ch, input int limit, output int first);
        first = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (dout[ch] && first == 0) first = i;
        end
    endtask

    int first;

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        ena         = 1'b1;
        din         = 8'h00;
        invert_mask = 8'h0F;
        mode        = 2'b00;
        db_limit    = 4'd3;
        cnt_clr     = 1'b0;
        ch_sel      = 3'd0;
        clear_watch(0);

        // 1: reset state, prime loads inverted levels silently
        tick(3);
        check("rst_dout", dout, 8'h00);
        check("rst_any_evt", any_evt, 1'b0);
        check("rst_count", evt_count, 8'h00);
        rst_n = 1'b1;
        tick(2);
        check("preprime_dout", dout, 8'h00);
        tick(1);
        check("prime_dout", dout, 8'h0F);
        check("prime_any_evt", any_evt, 1'b0);
        clear_watch(0);
        step_watch(8);
        check("prime_no_evt", evt_seen, 0);
        for (int c = 0; c < 8; c++) begin
            ch_sel = 3'(c);
            #1;
            check($sformatf("prime_count_ch%0d", c), evt_count, 8'h00);
        end
        // Dropping the inversion is an input change: falls only, no counts.
        invert_mask = 8'h00;
        clear_watch(0);
        step_watch(10);
        check("unmask_dout", dout, 8'h00);
        check("unmask_no_rise", evt_seen, 0);

        // 2: glitch shorter than db_limit+1 is rejected; held edge takes 6 cycles
        ch_sel = 3'd0;
        din[0] = 1'b1;
        tick(3);
        din[0] = 1'b0;
        clear_watch(0);
        step_watch(20);
        check("glitch_rejected", hi_cnt, 0);
        din[0] = 1'b1;
        wait_rise(0, 20, first);
        check("db_latency", first, 6);
        check("ch0_count", evt_count, 8'd1);
        din[0] = 1'b0;
        tick(10);
        check("ch0_fall", dout[0], 1'b0);

        // 3: rise mode, five clean pulses on ch 2
        mode     = 2'b01;
        ch_sel   = 3'd2;
        db_limit = 4'd1;
        clear_watch(2);
        for (int p = 0; p < 5; p++) begin
            din[2] = 1'b1;
            step_watch(6);
            din[2] = 1'b0;
            step_watch(6);
        end
        step_watch(6);
        check("rise_pulses", hi_cnt, 5);
        check("rise_single_cycle", dbl_cnt, 0);
        check("ch2_count", evt_count, 8'd5);
        mode = 2'b11;
        #1;
        check("toggle_ch2_ch0", dout[2:0], 3'b101);
        mode = 2'b00;
        #1;
        check("level_after_toggle", dout[2:0], 3'b000);

        // 4: saturation at 255, then clear coincident with a rise
        db_limit = 4'd0;
        ch_sel   = 3'd1;
        for (int p = 0; p < 300; p++) begin
            din[1] = 1'b1;
            tick(2);
            din[1] = 1'b0;
            tick(2);
        end
        tick(4);
        check("sat_count", evt_count, 8'd255);
        din[1] = 1'b1;
        tick(2);
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        check("clr_rise_seen", any_evt, 1'b1);
        check("clr_wins", evt_count, 8'd0);
        din[1] = 1'b0;
        tick(4);
        din[1] = 1'b1;
        tick(4);
        check("count_after_clr", evt_count, 8'd1);
        din[1] = 1'b0;
        tick(4);

        // 5: ena=0 freezes debounce; ena=1 updates after db_limit+1
        db_limit = 4'd3;
        ch_sel   = 3'd3;
        ena      = 1'b0;
        din[3]   = 1'b1;
        clear_watch(3);
        step_watch(10);
        check("frozen_dout", hi_cnt, 0);
        check("frozen_no_evt", evt_seen, 0);
        check("frozen_count", evt_count, 8'd0);
        ena = 1'b1;
        wait_rise(3, 10, first);
        check("ena_latency", first, 4);
        check("ena_count", evt_count, 8'd1);

        // 6: reset mid-debounce clears immediately, re-prime is silent
        din[3] = 1'b0;
        tick(4);
        check("pre_reset_dout", dout, 8'h08);
        rst_n = 1'b0;
        #1;
        check("mid_rst_dout", dout, 8'h00);
        check("mid_rst_count", evt_count, 8'h00);
        check("mid_rst_any_evt", any_evt, 1'b0);
        din    = 8'h20;
        ch_sel = 3'd5;
        tick(2);
        rst_n = 1'b1;
        clear_watch(5);
        step_watch(2);
        check("reprime_early", dout, 8'h00);
        step_watch(1);
        check("reprime_dout", dout, 8'h20);
        step_watch(10);
        check("reprime_no_evt", evt_seen, 0);
        check("reprime_count", evt_count, 8'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
